// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI-Lite response codes and write-FSM states
package axi_lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} wr_state_t;
endpackage

// File: rtl/axi_lite_fifo.sv
// axi_lite_fifo: synchronous FIFO with full/empty flags
// Ports: clk, reset_n (async active-low), i_push/i_data write side,
// i_pop/o_data read side (show-ahead), o_full, o_empty.
module axi_lite_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop) r_rptr <= r_rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  assign o_data = r_mem[r_rptr[AW-1:0]];
  // extra pointer MSB separates full (lap ahead) from empty (same lap)
  assign o_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = r_wptr == r_rptr;
endmodule

// File: rtl/axi_lite_wr_slave.sv
// axi_lite_wr_slave: AXI4-Lite write slave driving a register-file write strobe
// Ports: clk, reset_n (async active-low); AW channel AWADDR/AWVALID/AWREADY;
// W channel WDATA/WSTRB/WVALID/WREADY; B channel BRESP/BVALID/BREADY;
// register port wr_en (one-cycle strobe), wr_idx, wr_data, wr_strb.
module axi_lite_wr_slave import axi_lite_pkg::*; #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_REGS  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_W-1:0]           AWADDR,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [DATA_W-1:0]           WDATA,
  input  logic [DATA_W/8-1:0]         WSTRB,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic                        wr_en,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx,
  output logic [DATA_W-1:0]           wr_data,
  output logic [DATA_W/8-1:0]         wr_strb
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB = $clog2(BYTES);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] WIN = ADDR_W'(NUM_REGS * BYTES);
  logic w_aw_full, w_aw_empty, w_wd_full, w_wd_empty, w_pop, w_hit;
  logic [ADDR_W-1:0] w_addr, w_offset;
  logic [DATA_W+BYTES-1:0] w_wd;
  wr_state_t r_state, w_next;
  resp_t r_bresp;
  logic r_wr_en;
  logic [IW-1:0] r_wr_idx;
  logic [DATA_W-1:0] r_wr_data;
  logic [BYTES-1:0] r_wr_strb;
  // READY is gated by reset_n so it drops at once when reset asserts
  assign AWREADY = reset_n & ~w_aw_full;
  assign WREADY = reset_n & ~w_wd_full;
  axi_lite_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_aw (
    .clk(clk), .reset_n(reset_n), .i_push(AWVALID & AWREADY), .i_data(AWADDR),
    .i_pop(w_pop), .o_data(w_addr), .o_full(w_aw_full), .o_empty(w_aw_empty)
  );
  axi_lite_fifo #(.WIDTH(DATA_W + BYTES), .DEPTH(DEPTH)) u_wd (
    .clk(clk), .reset_n(reset_n), .i_push(WVALID & WREADY), .i_data({WSTRB, WDATA}),
    .i_pop(w_pop), .o_data(w_wd), .o_full(w_wd_full), .o_empty(w_wd_empty)
  );
  // join one AW with one W once the B slot is free or being freed this cycle
  assign w_pop = !w_aw_empty && !w_wd_empty && (!BVALID || BREADY);
  assign w_offset = w_addr - BASE_ADDR;
  assign w_hit = (w_addr >= BASE_ADDR) && (w_offset < WIN) && (w_offset[LB-1:0] == '0);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = w_pop ? RESP : (r_state == RESP && !BREADY) ? RESP : IDLE;
  always_comb BVALID = r_state == RESP;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_bresp <= OKAY;
      r_wr_en <= 1'b0;
      r_wr_idx <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
    end else begin
      r_wr_en <= w_pop && w_hit;
      if (w_pop) r_bresp <= w_hit ? OKAY : SLVERR;
      if (w_pop && w_hit) begin
        r_wr_idx <= w_offset[LB +: IW];
        r_wr_data <= w_wd[DATA_W-1:0];
        r_wr_strb <= w_wd[DATA_W +: BYTES];
      end
    end
  assign BRESP = r_bresp;
  assign wr_en = r_wr_en;
  assign wr_idx = r_wr_idx;
  assign wr_data = r_wr_data;
  assign wr_strb = r_wr_strb;
endmodule

// File: tb/tb_axi_lite_wr_slave.sv
// tb_axi_lite_wr_slave: randomized and directed bench against a queue-based model
module tb_axi_lite_wr_slave;
  localparam int DEPTH = 2;
  localparam int NUM_REGS = 16;
  logic clk = 0, reset_n = 0;
  logic [31:0] AWADDR = 0;
  logic AWVALID = 0, AWREADY;
  logic [31:0] WDATA = 0;
  logic [3:0] WSTRB = 0;
  logic WVALID = 0, WREADY;
  logic [1:0] BRESP;
  logic BVALID, BREADY = 1;
  logic wr_en;
  logic [3:0] wr_idx;
  logic [31:0] wr_data;
  logic [3:0] wr_strb;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  axi_lite_wr_slave #(.DEPTH(DEPTH), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset_n(reset_n), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_strb(wr_strb)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: accepted requests sit in queues; a join happens when both
  // queues hold something and no unaccepted response is pending.
  logic [31:0] aq[$];
  logic [35:0] wq[$];
  logic m_bv = 0, m_wen = 0;
  logic [1:0] m_bresp = 0;
  logic [3:0] m_idx = 0, m_strb = 0;
  logic [31:0] m_data = 0;
  function automatic bit in_win(input logic [31:0] a);
    return a < NUM_REGS * 4 && a % 4 == 0;
  endfunction
  always @(posedge clk or negedge reset_n) begin : mdl
    bit pop, hit, aw_acc, w_acc;
    logic [31:0] a;
    logic [35:0] d;
    if (!reset_n) begin
      aq.delete();
      wq.delete();
      m_bv <= 0;
      m_wen <= 0;
      m_bresp <= 0;
      m_idx <= 0;
      m_data <= 0;
      m_strb <= 0;
    end else begin
      aw_acc = AWVALID && aq.size() < DEPTH;
      w_acc = WVALID && wq.size() < DEPTH;
      pop = aq.size() > 0 && wq.size() > 0 && (!m_bv || BREADY);
      hit = 0;
      if (pop) begin
        a = aq.pop_front();
        d = wq.pop_front();
        hit = in_win(a);
        m_bresp <= hit ? 2'b00 : 2'b10;
        if (hit) begin
          m_idx <= 4'(a / 4);
          m_data <= d[31:0];
          m_strb <= d[35:32];
        end
      end
      m_bv <= pop || (m_bv && !BREADY);
      m_wen <= pop && hit;
      if (aw_acc) aq.push_back(AWADDR);
      if (w_acc) wq.push_back({WSTRB, WDATA});
    end
  end
  always @(negedge clk) if (reset_n) begin
    chk("awready", AWREADY, aq.size() < DEPTH);
    chk("wready", WREADY, wq.size() < DEPTH);
    chk("bvalid", BVALID, m_bv);
    if (m_bv) chk("bresp", BRESP, m_bresp);
    chk("wr_en", wr_en, m_wen);
    if (m_wen) begin
      chk("wr_idx", wr_idx, m_idx);
      chk("wr_data", wr_data, m_data);
      chk("wr_strb", wr_strb, m_strb);
    end
  end
  // Offer AW and/or W from a negedge and hold until each handshake; returns at
  // the negedge right after the last handshake edge.
  task automatic xfer(input bit do_aw, input bit do_w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    bit ad, wd;
    int n = 0;
    ad = !do_aw;
    wd = !do_w;
    AWADDR = a;
    WDATA = d;
    WSTRB = s;
    AWVALID = do_aw;
    WVALID = do_w;
    while (!(ad && wd) && n < 50) begin
      if (AWVALID && AWREADY) ad = 1;
      if (WVALID && WREADY) wd = 1;
      @(negedge clk);
      if (ad) AWVALID = 0;
      if (wd) WVALID = 0;
      n++;
    end
    chk("handshake_done", ad && wd, 1);
  endtask
  function automatic logic [31:0] raddr();
    return $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 'h4f)) : 32'($urandom_range(0, 19) * 4);
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bit aw_hs, w_hs;
    logic [1:0] br[5];
    logic bv[5];
    int cnt, first;
    repeat (2) @(negedge clk);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_strb", wr_strb, 0);
    @(posedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_wready", WREADY, 1);
    // same-cycle AW/W: strobe two cycles after the handshake
    xfer(1, 1, 32'h8, 32'hDEADBEEF, 4'hF);
    chk("t1_early_wr_en", wr_en, 0);
    @(negedge clk);
    chk("t1_wr_en", wr_en, 1);
    chk("t1_wr_idx", wr_idx, 2);
    chk("t1_wr_data", wr_data, 32'hDEADBEEF);
    chk("t1_bvalid", BVALID, 1);
    chk("t1_bresp", BRESP, 0);
    @(negedge clk);
    chk("t1_wr_en_drop", wr_en, 0);
    chk("t1_wr_idx_hold", wr_idx, 2);
    // W ahead of AW
    xfer(0, 1, 0, 32'h11, 4'hF);
    repeat (3) begin
      chk("t2_no_wr_en", wr_en, 0);
      chk("t2_no_bvalid", BVALID, 0);
      @(negedge clk);
    end
    xfer(1, 0, 32'h4, 0, 0);
    @(negedge clk);
    chk("t2_wr_en", wr_en, 1);
    chk("t2_wr_idx", wr_idx, 1);
    chk("t2_wr_data", wr_data, 32'h11);
    chk("t2_bresp", BRESP, 0);
    // out of range and misaligned
    xfer(1, 1, 32'h40, 32'hAA, 4'hF);
    @(negedge clk);
    chk("t3_oor_wr_en", wr_en, 0);
    chk("t3_oor_bvalid", BVALID, 1);
    chk("t3_oor_bresp", BRESP, 2);
    xfer(1, 1, 32'h6, 32'hBB, 4'hF);
    @(negedge clk);
    chk("t3_mis_wr_en", wr_en, 0);
    chk("t3_mis_bvalid", BVALID, 1);
    chk("t3_mis_bresp", BRESP, 2);
    @(negedge clk);
    // backpressure: 1 response + DEPTH entries per FIFO, then stall
    BREADY = 0;
    xfer(1, 1, 32'h10, 32'h1, 4'h1);
    xfer(1, 1, 32'h44, 32'h2, 4'h2);
    xfer(1, 1, 32'h18, 32'h3, 4'h3);
    chk("t4_bvalid", BVALID, 1);
    chk("t4_awready_stall", AWREADY, 0);
    chk("t4_wready_stall", WREADY, 0);
    chk("t4_bresp", BRESP, 0);
    fork
      xfer(1, 1, 32'h1C, 32'h4, 4'h4);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t4_bresp_stable", BRESP, 0);
          chk("t4_bvalid_held", BVALID, 1);
        end
        BREADY = 1;
        for (int i = 0; i < 5; i++) begin
          bv[i] = BVALID;
          br[i] = BRESP;
          @(negedge clk);
        end
      end
    join
    chk("t4_r0", {bv[0], br[0]}, 3'b1_00);
    chk("t4_r1", {bv[1], br[1]}, 3'b1_10);
    chk("t4_r2", {bv[2], br[2]}, 3'b1_00);
    chk("t4_r3", {bv[3], br[3]}, 3'b1_00);
    chk("t4_r4_idle", bv[4], 0);
    // back-to-back stream across pointer wrap
    cnt = 0;
    first = -1;
    fork
      for (int k = 0; k < 8; k++) xfer(1, 1, 32'(k * 4), 32'h100 + 32'(k), 4'hF);
      for (int i = 0; i < 14; i++) begin
        if (wr_en) begin
          if (first < 0) first = i;
          chk("t5_idx_seq", wr_idx, 64'(i - first));
          cnt++;
        end
        @(negedge clk);
      end
    join
    chk("t5_count", cnt, 8);
    // reset with a response pending and one entry in each FIFO
    BREADY = 0;
    xfer(1, 1, 32'h20, 32'h55, 4'hF);
    xfer(1, 1, 32'h24, 32'h66, 4'hF);
    chk("t6_bvalid_before", BVALID, 1);
    chk("t6_awready_before", AWREADY, 1);
    #2 reset_n = 0;
    #1;
    chk("t6_async_bvalid", BVALID, 0);
    chk("t6_async_wr_en", wr_en, 0);
    chk("t6_async_awready", AWREADY, 0);
    chk("t6_async_wready", WREADY, 0);
    @(posedge clk);
    #2 reset_n = 1;
    BREADY = 1;
    @(negedge clk);
    chk("t6_awready_after", AWREADY, 1);
    chk("t6_wready_after", WREADY, 1);
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_stale_b", BVALID, 0);
      chk("t6_no_stale_wr", wr_en, 0);
    end
    // randomized traffic, model-checked every cycle
    aw_hs = 0;
    w_hs = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (aw_hs || !AWVALID) begin
        AWVALID = $urandom_range(0, 2) != 0;
        AWADDR = raddr();
      end
      if (w_hs || !WVALID) begin
        WVALID = $urandom_range(0, 2) != 0;
        WDATA = $urandom;
        WSTRB = 4'($urandom_range(0, 15));
      end
      BREADY = $urandom_range(0, 3) != 0;
      aw_hs = AWVALID && AWREADY;
      w_hs = WVALID && WREADY;
    end
    @(negedge clk);
    if (!aw_hs) AWVALID = AWVALID;
    AWVALID = 0;
    WVALID = 0;
    BREADY = 1;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_wr_slave.md
# axi_lite_wr_slave

Parametrised AXI4-Lite write-path slave covering all three write channels (AW, W, B). It buffers address and data independently in per-channel FIFOs so either may arrive first. It joins one AW with one W, decodes the address against a register window, and drives a single-cycle write strobe into a register file. It returns one B response per transaction and sits between the interconnect and any register block.

## Interface
Parameters:
- ADDR_W, 32, AWADDR width
- DATA_W, 32, WDATA width; 32 or 64
- DEPTH, 2, entries per AW/W FIFO; power of two, ≥2
- BASE_ADDR, 0, byte address of register 0
- NUM_REGS, 16, registers in the window; ≥2

Ports:
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  reset, asynchronous assert, active-low
- AWADDR  in  ADDR_W  write address
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte strobes
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- BRESP  out  2  response
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- wr_en  out  1  one-cycle register write strobe
- wr_idx  out  $clog2(NUM_REGS)  register index
- wr_data  out  DATA_W  write data
- wr_strb  out  DATA_W/8  byte enables

## Operation
- Reset is asynchronous and active-low. It forces AWREADY=0, WREADY=0, BVALID=0, BRESP=2'b00, wr_en=0, wr_idx=0, wr_data=0, wr_strb=0, empties both FIFOs, and sets the FSM to IDLE.
- AW FIFO:
  - AWREADY = !aw_full.
  - Push on AWVALID&&AWREADY.
- W FIFO:
  - WREADY = !w_full.
  - Push on WVALID&&WREADY.
  - WDATA and WSTRB are stored together.
- Join condition: a pop occurs when both FIFOs are non-empty and the B slot is free (!BVALID, or BVALID&&BREADY in the same cycle). The pop removes one entry from each FIFO simultaneously.
- Decode, with offset = AWADDR−BASE_ADDR and BYTES = DATA_W/8:
  - A hit requires AWADDR≥BASE_ADDR, offset < NUM_REGS*BYTES, and offset[$clog2(BYTES)-1:0]==0.
  - Hit: register wr_en=1, wr_idx=offset>>$clog2(BYTES), wr_data, wr_strb; BRESP=OKAY (2'b00).
  - Miss or misaligned: wr_en=0, BRESP=SLVERR (2'b10). The register file is never written.
  - WSTRB=0 on a hit: wr_en=1 with wr_strb=0, BRESP=OKAY.
- FSM:
  - IDLE→RESP on pop.
  - RESP→RESP on pop with BREADY (back-to-back).
  - RESP→IDLE on BREADY with no pop.
  - RESP holds otherwise.
  - BVALID=1 exactly in RESP. BRESP is stable while BVALID&&!BREADY.
- wr_en is high for exactly one cycle per hit pop; wr_idx, wr_data and wr_strb hold their last values after it drops.
- Responses are returned in acceptance order. There is no reordering or ID.
- Simultaneous push and pop on a full FIFO is illegal, because READY is already 0. Simultaneous push and pop on a non-full FIFO keeps the count unchanged.

## Timing
- Latency: a handshake on the last of AW/W at edge T gives a FIFO entry visible in cycle T+1, with the pop at edge T+1. wr_en and BVALID are high in cycle T+2.
- Throughput is one transaction per cycle while BREADY=1 and both FIFOs are supplied.
- With BREADY=0, at most 1 response plus DEPTH AW and DEPTH W entries are outstanding. Further AW/W stall via READY=0.
- FIFO pointers are $clog2(DEPTH)+1 bits wide. full = MSBs differ and the rest are equal; empty = pointers equal. Pointers wrap naturally.
- Reset asserted mid-transaction drops all pending and in-flight transactions. Outputs go to reset values immediately (asynchronously), without waiting for a clock edge.

## Structure
- Package axi_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - wr_state_t enum: IDLE, RESP
- Sub-module axi_lite_fifo #(WIDTH, DEPTH), a synchronous FIFO with full/empty and asynchronous active-low reset. It is instantiated twice: AW with WIDTH=ADDR_W, and W with WIDTH=DATA_W+DATA_W/8.
- Top level contains only decode, the FSM and the output registers.

## Test plan
- AW 0x8 and W 0xDEADBEEF/strb 0xF in the same cycle, BREADY=1 → wr_en one cycle at T+2 with wr_idx=2, wr_data=0xDEADBEEF; BVALID=1, BRESP=2'b00 at T+2.
- W 0x11 three cycles before AW 0x4 → no wr_en until AW arrives. Then wr_idx=1, wr_data=0x11, BRESP=OKAY.
- AW 0x40 (out of range, NUM_REGS=16) and AW 0x6 (misaligned) → wr_en stays 0 and BRESP=2'b10 for each.
- BREADY=0 and push 4 AW+W pairs with DEPTH=2:
  - Required: BVALID=1 and AWREADY=WREADY=0 after 3 pairs are accepted, with BRESP stable.
  - On releasing BREADY=1: 4 responses, one per cycle, in order.
- Stream 8 back-to-back pairs to addresses 0x0…0x1C with BREADY=1 → wr_en high 8 consecutive cycles, wr_idx 0…7, pointers wrap with no loss.
- Assert reset_n=0 while BVALID=1 and both FIFOs hold 1 entry → BVALID, wr_en, AWREADY and WREADY are 0 immediately. After release, AWREADY=WREADY=1, FIFOs are empty, and no stale response appears.
